// File: rtl/mem_bus_if_pkg.sv
// Shared definitions for the mem_bus_if memory bus interface: state encoding,
// default watchdog limit and an address-alignment helper.
package mem_bus_if_pkg;

    localparam logic [1:0] MB_IDLE   = 2'd0;
    localparam logic [1:0] MB_ACCESS = 2'd1;
    localparam logic [1:0] MB_DONE   = 2'd2;
    localparam logic [1:0] MB_ERROR  = 2'd3;

    localparam int unsigned MB_TIMEOUT_DEFAULT = 255;

    typedef enum logic [1:0] {
        StIdle   = MB_IDLE,
        StAccess = MB_ACCESS,
        StDone   = MB_DONE,
        StError  = MB_ERROR
    } mb_state_e;

    function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
        return addr_lsb == 2'b00;
    endfunction

endpackage

// File: rtl/mem_bus_if_en_reg.sv
// Generic enable register with asynchronous active-low reset; holds its value
// until the next cycle with iEn high.
module mem_bus_if_en_reg #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             iClk,
    input  logic             nRst,
    input  logic             iEn,
    input  logic [WIDTH-1:0] iD,
    output logic [WIDTH-1:0] oQ
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            r_q <= '0;
        end else if (iEn) begin
            r_q <= iD;
        end
    end

    assign oQ = r_q;

endmodule

// File: rtl/mem_bus_if.sv
// Multi-cycle strobe/ack memory bus interface for the processor datapath.
// Optional ack watchdog is compiled in with `define MEM_BUS_TIMEOUT_EN.
module mem_bus_if
    import mem_bus_if_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = MB_TIMEOUT_DEFAULT,
    parameter bit          ALIGN_CHECK    = 1'b1
) (
    input  logic        iClk,
    input  logic        nRst,
    input  logic        iReq_rd,
    input  logic        iReq_wr,
    input  logic [31:0] iAddr,
    input  logic [31:0] iWData,
    output logic [31:0] oRData,
    output logic        oBusy,
    output logic        oDone,
    output logic        oErr,
    output logic [31:0] oBus_addr,
    output logic [31:0] oBus_wdata,
    output logic        oBus_rd,
    output logic        oBus_wr,
    input  logic        iBus_ack,
    input  logic [31:0] iBus_rdata
);

    mb_state_e   r_state;
    mb_state_e   w_state_d;
    logic        w_accept;
    logic        w_timeout;
    logic        w_rdata_en;
    logic [31:0] r_bus_addr;
    logic [31:0] r_bus_wdata;
    logic        r_dir_rd;

    always_comb begin
        w_state_d = r_state;
        w_accept  = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (iReq_rd && iReq_wr) begin
                    w_state_d = StError;
                end else if (iReq_rd || iReq_wr) begin
                    if (ALIGN_CHECK && !is_word_aligned(iAddr[1:0])) begin
                        w_state_d = StError;
                    end else begin
                        w_state_d = StAccess;
                        w_accept  = 1'b1;
                    end
                end
            end
            StAccess: begin
                // Ack takes priority over a watchdog expiry in the same cycle.
                if (iBus_ack) begin
                    w_state_d = StDone;
                end else if (w_timeout) begin
                    w_state_d = StError;
                end
            end
            StDone:  w_state_d = StIdle;
            StError: w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_dir_rd    <= 1'b0;
        end else if (w_accept) begin
            r_bus_addr  <= iAddr;
            r_bus_wdata <= iWData;
            r_dir_rd    <= iReq_rd;
        end
    end

`ifdef MEM_BUS_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CntW-1:0] r_wait_cnt;
    logic [CntW-1:0] w_wait_cnt_inc;

    assign w_wait_cnt_inc = r_wait_cnt + CntW'(1);
    assign w_timeout      = (w_wait_cnt_inc == CntW'(TIMEOUT_CYCLES));

    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            r_wait_cnt <= '0;
        end else if (w_accept) begin
            r_wait_cnt <= '0;
        end else if ((r_state == StAccess) && !iBus_ack) begin
            r_wait_cnt <= w_wait_cnt_inc;
        end
    end
`else
    // Without the watchdog the limit is irrelevant; ACCESS waits for ack forever.
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES == 0);
    assign w_timeout        = 1'b0;
`endif

    assign w_rdata_en = (r_state == StAccess) && iBus_ack && r_dir_rd;

    mem_bus_if_en_reg #(
        .WIDTH(32)
    ) u_rdata_reg (
        .iClk(iClk),
        .nRst(nRst),
        .iEn (w_rdata_en),
        .iD  (iBus_rdata),
        .oQ  (oRData)
    );

    assign oBusy      = (r_state != StIdle);
    assign oDone      = (r_state == StDone);
    assign oErr       = (r_state == StError);
    assign oBus_addr  = r_bus_addr;
    assign oBus_wdata = r_bus_wdata;
    assign oBus_rd    = (r_state == StAccess) && r_dir_rd;
    assign oBus_wr    = (r_state == StAccess) && !r_dir_rd;

endmodule
